// File: rtl/vpg_pattern_engine.sv
// Raster timing plus an 8-pattern colour generator with an 8-bit Avalon-MM register
// slave. The outputs come from a two-stage pipeline running on the pixel clock.
module vpg_pattern_engine #(
  parameter int COLOR_BITS = 8,
  parameter int H_DISP     = 640,
  parameter int H_FPORCH   = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BPORCH   = 48,
  parameter int V_DISP     = 480,
  parameter int V_FPORCH   = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BPORCH   = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_cs_n,
  input  logic [1:0]            s_address,
  input  logic                  s_write,
  input  logic [7:0]            s_writedata,
  input  logic                  s_read,
  output logic [7:0]            s_readdata,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_de,
  output logic [COLOR_BITS-1:0] vga_r,
  output logic [COLOR_BITS-1:0] vga_g,
  output logic [COLOR_BITS-1:0] vga_b
);
  localparam int H_TOT  = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;
  localparam int V_TOT  = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;
  localparam int HS_BEG = H_DISP + H_FPORCH;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_DISP + V_FPORCH;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam int HCW    = ($clog2(H_TOT) > COLOR_BITS) ? $clog2(H_TOT) : COLOR_BITS;
  localparam int VCW    = ($clog2(V_TOT) > 1) ? $clog2(V_TOT) : 1;
  localparam int BAR_W  = H_DISP / 8;
  localparam logic [COLOR_BITS-1:0] CMAX = '1;

  logic [HCW-1:0]        h_cnt_q, h_cnt_d;
  logic [VCW-1:0]        v_cnt_q, v_cnt_d;
  logic [2:0]            pattern_q, pattern_d, shadow_q, shadow_d, ck_shift_q, ck_shift_d;
  logic                  enable_q, enable_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d, rdata_d;
  logic                  wr_en, rd_en, line_end, frame_end, de_raw, hs_raw, vs_raw;
  logic                  hs_p1_q, vs_p1_q, de_p1_q;
  logic [COLOR_BITS-1:0] r_p1_q, g_p1_q, b_p1_q, pix_r, pix_g, pix_b, ramp;
  logic [2:0]            bar;
  logic                  wdata_unused;

  assign wr_en        = !s_cs_n && s_write;
  assign rd_en        = !s_cs_n && s_read && !s_write;
  assign line_end     = (int'(h_cnt_q) == H_TOT - 1);
  assign frame_end    = line_end && (int'(v_cnt_q) == V_TOT - 1);
  assign de_raw       = (int'(h_cnt_q) < H_DISP) && (int'(v_cnt_q) < V_DISP);
  assign hs_raw       = (int'(h_cnt_q) >= HS_BEG) && (int'(h_cnt_q) < HS_END);
  assign vs_raw       = (int'(v_cnt_q) >= VS_BEG) && (int'(v_cnt_q) < VS_END);
  assign wdata_unused = ^s_writedata[7:3];

  // Register file, counters and the frame-synchronous pattern shadow.
  always_comb begin
    pattern_d  = pattern_q;
    enable_d   = enable_q;
    ck_shift_d = ck_shift_q;
    if (wr_en) begin
      case (s_address)
        2'd0:    pattern_d  = s_writedata[2:0];
        2'd1:    enable_d   = s_writedata[0];
        2'd3:    ck_shift_d = s_writedata[2:0];
        default: ;
      endcase
    end
    // pattern_d (not pattern_q) so a write landing on the frame-end cycle is kept.
    shadow_d    = frame_end ? pattern_d : shadow_q;
    frame_cnt_d = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;
    h_cnt_d     = line_end ? '0 : h_cnt_q + HCW'(1);
    v_cnt_d     = v_cnt_q;
    if (line_end)
      v_cnt_d = (int'(v_cnt_q) == V_TOT - 1) ? '0 : v_cnt_q + VCW'(1);
    rdata_d = s_readdata;
    if (rd_en) begin
      case (s_address)
        2'd0:    rdata_d = {5'd0, pattern_q};
        2'd1:    rdata_d = {7'd0, enable_q};
        2'd2:    rdata_d = frame_cnt_q;
        default: rdata_d = {5'd0, ck_shift_q};
      endcase
    end
  end

  always_comb begin
    ramp = h_cnt_q[COLOR_BITS-1:0];
    bar  = 3'd0;
    for (int k = 1; k < 8; k++)
      if (int'(h_cnt_q) >= k * BAR_W) bar = 3'(k);
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (shadow_q)
      3'd0: begin
        if (int'(v_cnt_q) < V_DISP / 4)          pix_r = ramp;
        else if (int'(v_cnt_q) < V_DISP / 2)     pix_g = ramp;
        else if (int'(v_cnt_q) < 3 * V_DISP / 4) pix_b = ramp;
        else begin
          pix_r = ramp;
          pix_g = ramp;
          pix_b = ramp;
        end
      end
      3'd1: pix_r = CMAX;
      3'd2: pix_g = CMAX;
      3'd3: pix_b = CMAX;
      3'd4: begin
        pix_r = CMAX;
        pix_g = CMAX;
        pix_b = CMAX;
      end
      // Bar index bits map straight onto the colour-bar channel pattern.
      3'd6: begin
        pix_r = bar[1] ? '0 : CMAX;
        pix_g = bar[2] ? '0 : CMAX;
        pix_b = bar[0] ? '0 : CMAX;
      end
      3'd7: begin
        // The square that holds the origin is white.
        if ((((int'(h_cnt_q) ^ int'(v_cnt_q)) >> ck_shift_q) & 1) == 0) begin
          pix_r = CMAX;
          pix_g = CMAX;
          pix_b = CMAX;
        end
      end
      default: ;
    endcase
    if (!de_raw || !enable_q) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      pattern_q   <= 3'd0;
      shadow_q    <= 3'd0;
      enable_q    <= 1'b1;
      ck_shift_q  <= 3'd4;
      frame_cnt_q <= 8'd0;
      s_readdata  <= 8'd0;
      hs_p1_q     <= ~HS_POL;
      vs_p1_q     <= ~VS_POL;
      de_p1_q     <= 1'b0;
      r_p1_q      <= '0;
      g_p1_q      <= '0;
      b_p1_q      <= '0;
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_de      <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      pattern_q   <= pattern_d;
      shadow_q    <= shadow_d;
      enable_q    <= enable_d;
      ck_shift_q  <= ck_shift_d;
      frame_cnt_q <= frame_cnt_d;
      s_readdata  <= rdata_d;
      // Stage 1: sync, enable and colour captured from the counters
      hs_p1_q     <= hs_raw ? HS_POL : ~HS_POL;
      vs_p1_q     <= vs_raw ? VS_POL : ~VS_POL;
      de_p1_q     <= de_raw && enable_q;
      r_p1_q      <= pix_r;
      g_p1_q      <= pix_g;
      b_p1_q      <= pix_b;
      // Stage 2: output registers
      vga_hs      <= hs_p1_q;
      vga_vs      <= vs_p1_q;
      vga_de      <= de_p1_q;
      vga_r       <= r_p1_q;
      vga_g       <= g_p1_q;
      vga_b       <= b_p1_q;
    end
  end
endmodule

// File: tb/tb_vpg_pattern_engine.sv
// Bench for vpg_pattern_engine on a small 24x12 raster: a per-cycle scoreboard,
// a register vector table and hand-written timing/pattern sequences.
module tb_vpg_pattern_engine;
  localparam int HD = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VD = 8, VF = 1, VSY = 2, VB = 1;
  localparam int HT = HD + HF + HSY + HB;
  localparam int VT = VD + VF + VSY + VB;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_cs_n = 1'b1, s_write = 1'b0, s_read = 1'b0;
  logic [1:0] s_address = 2'd0;
  logic [7:0] s_writedata = 8'd0;
  logic [7:0] s_readdata;
  logic       vga_hs, vga_vs, vga_de;
  logic [7:0] vga_r, vga_g, vga_b;

  always #5 clk = ~clk;

  vpg_pattern_engine #(
    .COLOR_BITS(8), .H_DISP(HD), .H_FPORCH(HF), .H_SYNC(HSY), .H_BPORCH(HB),
    .V_DISP(VD), .V_FPORCH(VF), .V_SYNC(VSY), .V_BPORCH(VB), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .s_cs_n(s_cs_n), .s_address(s_address), .s_write(s_write),
    .s_writedata(s_writedata), .s_read(s_read), .s_readdata(s_readdata),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  typedef struct {
    logic        valid;
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    logic       do_wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  exp_t       sbq[$];
  exp_t       cur_exp;
  int         mh, mv, mpat, msh, mck, mfc;
  logic       men;
  logic [7:0] rd_exp;
  int         n_tests = 0, n_fail = 0;
  logic       chk_en = 1'b0;

  function automatic logic [23:0] ref_rgb(int x, int y, int pat, int ck);
    logic [7:0] gg;
    gg = 8'(x);
    case (pat)
      0: begin
        if (y < VD / 4)          return {gg, 16'h0};
        else if (y < VD / 2)     return {8'h0, gg, 8'h0};
        else if (y < 3 * VD / 4) return {16'h0, gg};
        else                     return {gg, gg, gg};
      end
      1: return 24'hFF0000;
      2: return 24'h00FF00;
      3: return 24'h0000FF;
      4: return 24'hFFFFFF;
      6: return BARS[x / (HD / 8)];
      7: return ((((x >> ck) ^ (y >> ck)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.valid = 1'b0; e.h = -1; e.v = -1;
    e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.rgb = 24'h0;
    return e;
  endfunction

  function automatic exp_t make_exp(int h, int v, int pat, logic en, int ck);
    exp_t e;
    e.valid = 1'b1; e.h = h; e.v = v;
    e.hs  = !((h >= HD + HF) && (h < HD + HF + HSY));
    e.vs  = !((v >= VD + VF) && (v < VD + VF + VSY));
    e.de  = (h < HD) && (v < VD) && en;
    e.rgb = e.de ? ref_rgb(h, v, pat, ck) : 24'h0;
    return e;
  endfunction

  // Reference model: at each edge push what stage 1 captures, pop what the outputs now show.
  always @(posedge clk) begin
    if (reset) begin
      sbq.delete();
      sbq.push_back(rst_exp());
      cur_exp = rst_exp();
      mh = 0; mv = 0; mpat = 0; msh = 0; men = 1'b1; mck = 4; mfc = 0; rd_exp = 8'h00;
    end else begin
      if (sbq.size() > 0) cur_exp = sbq.pop_front();
      else                cur_exp = rst_exp();
      sbq.push_back(make_exp(mh, mv, msh, men, mck));
      if (!s_cs_n && s_read && !s_write) begin
        case (s_address)
          2'd0: rd_exp = 8'(mpat);
          2'd1: rd_exp = {7'd0, men};
          2'd2: rd_exp = 8'(mfc);
          default: rd_exp = 8'(mck);
        endcase
      end
      if (!s_cs_n && s_write) begin
        case (s_address)
          2'd0: mpat = int'(s_writedata[2:0]);
          2'd1: men  = s_writedata[0];
          2'd3: mck  = int'(s_writedata[2:0]);
          default: ;
        endcase
      end
      if (mh == HT - 1 && mv == VT - 1) begin
        msh = mpat;
        mfc = (mfc + 1) % 256;
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if ({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, s_readdata} !==
          {cur_exp.hs, cur_exp.vs, cur_exp.de, cur_exp.rgb, rd_exp}) begin
        n_fail++;
        $display("FAIL scoreboard h=%0d v=%0d: got hs/vs/de=%b%b%b rgb=%h rd=%h, expected %b%b%b rgb=%h rd=%h",
                 cur_exp.h, cur_exp.v, vga_hs, vga_vs, vga_de, {vga_r, vga_g, vga_b}, s_readdata,
                 cur_exp.hs, cur_exp.vs, cur_exp.de, cur_exp.rgb, rd_exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Returns at the falling edge where the outputs show pixel (x,y).
  task automatic wait_out(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cur_exp.valid && cur_exp.h == x && cur_exp.v == y) && n < 2 * HT * VT);
    if (!(cur_exp.valid && cur_exp.h == x && cur_exp.v == y)) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_out(%0d,%0d): position not reached in %0d cycles", x, y, n);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    s_cs_n = 1'b0; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_cs_n = 1'b1; s_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    s_cs_n = 1'b0; s_read = 1'b1; s_address = a;
    @(negedge clk);
    s_cs_n = 1'b1; s_read = 1'b0;
    d = s_readdata;
  endtask

  initial begin
    vec_t       tbl[10];
    logic [7:0] rd;
    int         cnt;
    tbl[0] = '{1'b0, 2'd0, 8'h00, 8'h01};
    tbl[1] = '{1'b1, 2'd0, 8'hFD, 8'h05};
    tbl[2] = '{1'b1, 2'd0, 8'h01, 8'h01};
    tbl[3] = '{1'b1, 2'd3, 8'hFB, 8'h03};
    tbl[4] = '{1'b1, 2'd3, 8'h04, 8'h04};
    tbl[5] = '{1'b0, 2'd1, 8'h00, 8'h01};
    tbl[6] = '{1'b1, 2'd1, 8'hFE, 8'h00};
    tbl[7] = '{1'b1, 2'd1, 8'h01, 8'h01};
    tbl[8] = '{1'b0, 2'd2, 8'h00, 8'h02};
    tbl[9] = '{1'b1, 2'd2, 8'h55, 8'h02};

    reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_hs", vga_hs, 1);
    chk("rst_vs", vga_vs, 1);
    chk("rst_de", vga_de, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_rd", s_readdata, 0);
    reset = 1'b0;

    // Frame 0: SCALE and raster timing
    wait_out(0, 0);   chk("scale_0_0", {vga_r, vga_g, vga_b}, 24'h000000);
    wait_out(5, 0);   chk("scale_5_0", {vga_r, vga_g, vga_b}, 24'h050000);
    wait_out(15, 0);  chk("de_last", vga_de, 1);
    wait_out(16, 0);  chk("de_off", vga_de, 0);
    wait_out(17, 0);  chk("hs_before", vga_hs, 1);
    wait_out(18, 0);  chk("hs_first", vga_hs, 0);
    wait_out(20, 0);  chk("hs_last", vga_hs, 0);
    wait_out(21, 0);  chk("hs_after", vga_hs, 1);
    wait_out(0, 1);
    cnt = int'(vga_de);
    repeat (HT - 1) begin
      @(negedge clk);
      cnt += int'(vga_de);
    end
    chk("de_per_line", cnt, 16);
    wait_out(5, 2);   chk("scale_green", {vga_r, vga_g, vga_b}, 24'h000500);
    wait_out(5, 4);   chk("scale_blue", {vga_r, vga_g, vga_b}, 24'h000005);
    wait_out(5, 6);   chk("scale_gray", {vga_r, vga_g, vga_b}, 24'h050505);
    wait_out(0, 8);   chk("vs_before", vga_vs, 1); chk("de_blank", vga_de, 0);
    wait_out(0, 9);   chk("vs_first", vga_vs, 0);
    wait_out(23, 10); chk("vs_last", vga_vs, 0);
    wait_out(0, 11);  chk("vs_after", vga_vs, 1);

    // Mid-frame PATTERN write only shows from the next frame
    wait_out(0, 3);
    bus_write(2'd0, 8'h01);
    bus_read(2'd0, rd); chk("rd_pattern", rd, 8'h01);
    wait_out(5, 6);   chk("frame_keeps_scale", {vga_r, vga_g, vga_b}, 24'h050505);
    wait_out(0, 0);   chk("red_at_origin", {vga_r, vga_g, vga_b}, 24'hFF0000);
    wait_out(15, 7);  chk("red_last_pix", {vga_r, vga_g, vga_b}, 24'hFF0000);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].do_wr) bus_write(tbl[i].addr, tbl[i].wdata);
      bus_read(tbl[i].addr, rd);
      chk($sformatf("regvec%0d", i), rd, tbl[i].exp);
    end

    // Write and read together: the write lands, readdata holds
    bus_read(2'd3, rd); chk("rd_ck", rd, 8'h04);
    s_cs_n = 1'b0; s_write = 1'b1; s_read = 1'b1; s_address = 2'd0; s_writedata = 8'h02;
    @(negedge clk);
    s_cs_n = 1'b1; s_write = 1'b0; s_read = 1'b0;
    chk("wr_wins_hold", s_readdata, 8'h04);
    bus_read(2'd0, rd); chk("wr_wins_value", rd, 8'h02);

    // Colour bars
    wait_out(0, 4);
    bus_write(2'd0, 8'h06);
    wait_out(0, 0);
    for (int x = 0; x < HD; x++) begin
      if (x > 0) wait_out(x, 0);
      chk($sformatf("bars_x%0d", x), {vga_r, vga_g, vga_b}, BARS[x / 2]);
    end

    // Checkerboard, then CK_SHIFT change within the frame
    wait_out(0, 4);
    bus_write(2'd3, 8'h01);
    bus_write(2'd0, 8'h07);
    wait_out(0, 0);   chk("ck1_0_0", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
    wait_out(2, 0);   chk("ck1_2_0", {vga_r, vga_g, vga_b}, 24'h000000);
    wait_out(2, 2);   chk("ck1_2_2", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
    bus_write(2'd3, 8'h00);
    wait_out(0, 5);   chk("ck0_0_5", {vga_r, vga_g, vga_b}, 24'h000000);
    wait_out(1, 5);   chk("ck0_1_5", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
    wait_out(2, 5);   chk("ck0_2_5", {vga_r, vga_g, vga_b}, 24'h000000);

    // FRAME_CNT wrap from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (255 * HT * VT) @(negedge clk);
    bus_read(2'd2, rd); chk("fc_255", rd, 8'hFF);
    repeat (HT * VT - 1) @(negedge clk);
    bus_read(2'd2, rd); chk("fc_wrap", rd, 8'h00);
    bus_write(2'd2, 8'h55);
    bus_read(2'd2, rd); chk("fc_ro", rd, 8'h00);
    repeat (HT * VT) @(negedge clk);
    bus_read(2'd2, rd); chk("fc_one", rd, 8'h01);

    // ENABLE=0 mid-line blanks video after the pipeline drains; sync keeps running
    wait_out(4, 3);
    bus_write(2'd1, 8'h00);
    chk("en_lat1", vga_de, 1);
    @(negedge clk); chk("en_lat2", vga_de, 1);
    @(negedge clk); chk("en_off_de", vga_de, 0);
    chk("en_off_rgb", {vga_r, vga_g, vga_b}, 0);
    wait_out(18, 3);  chk("en_off_hs", vga_hs, 0);
    wait_out(21, 3);  chk("en_off_hs_end", vga_hs, 1);
    wait_out(0, 9);   chk("en_off_vs", vga_vs, 0);

    // Reset mid-frame
    bus_write(2'd0, 8'h03);
    bus_read(2'd3, rd); chk("pre_rst_ck", rd, 8'h04);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_hs", vga_hs, 1);
    chk("mid_rst_vs", vga_vs, 1);
    chk("mid_rst_de", vga_de, 0);
    chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("mid_rst_rd", s_readdata, 0);
    reset = 1'b0;
    bus_read(2'd0, rd); chk("rst_pattern", rd, 8'h00);
    bus_read(2'd1, rd); chk("rst_enable", rd, 8'h01);
    @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
